instr_encoder: RTL and testbench



---
 rtl/instr_encoder.sv | 161 ++++++++++++++++
 tb/tb_instr_encoder.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder
//   Packs symbolic MIPS instruction requests into 32-bit words and writes
//   them to consecutive instruction-memory addresses, starting at BASE_ADDR
//   after every start pulse.
//
// Handshake: a request is taken on a rising edge where in_valid and
//   in_ready are both high. in_ready is high only in ACCEPT while start is
//   low. Request fields are sampled only at that edge. Each accepted legal
//   request produces exactly one write cycle, so the peak rate is one word
//   every two cycles.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             restarts a load session; wins over everything else
//   in_valid/in_ready request handshake
//   in_op             0 NOP,1 ADD,2 SUB,3 AND,4 OR,5 SLT,6 LW,7 SW,8 ADDI,
//                     9 ANDI,10 J,11 BEQ,12 BNE,13-15 illegal
//   in_rs/rt/rd       register fields
//   in_imm            immediate / branch offset
//   in_target         jump target
//   in_last           final request of the session
//   memWrite/memAddr/memData  instruction-memory write port
//   busy, done, err   status (busy in ACCEPT/WRITE, done/err held)
//   count             words written in the current session
//   state_o           FSM state: 0 IDLE, 1 ACCEPT, 2 WRITE, 3 DONE, 4 ERROR
module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              memWrite,
  output logic [ADDR_W-1:0] memAddr,
  output logic [31:0]       memData,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_WRITE  = 3'd2,
    S_DONE   = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   count_q;
  logic [31:0]       word_q;
  logic              last_q;

  logic              op_legal;
  logic [31:0]       enc_word;

  function automatic logic [31:0] encode(
    input logic [3:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] w;
    w = 32'h0;
    case (op)
      4'd1:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};  // ADD
      4'd2:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};  // SUB
      4'd3:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};  // AND
      4'd4:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};  // OR
      4'd5:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};  // SLT
      4'd6:    w = {6'b100011, rs, rt, imm};                      // LW
      4'd7:    w = {6'b101011, rs, rt, imm};                      // SW
      4'd8:    w = {6'b001000, rs, rt, imm};                      // ADDI
      4'd9:    w = {6'b001100, rs, rt, imm};                      // ANDI
      4'd10:   w = {6'b000010, target};                           // J
      4'd11:   w = {6'b000100, rs, rt, imm};                      // BEQ
      4'd12:   w = {6'b000101, rs, rt, imm};                      // BNE
      default: w = 32'h0;                                         // NOP
    endcase
    return w;
  endfunction

  assign op_legal = (in_op <= 4'd12);
  assign enc_word = encode(in_op, in_rs, in_rt, in_rd, in_imm, in_target);

  // in_ready and memWrite look at start directly so a start pulse blocks
  // acceptance and suppresses the write in the very cycle it is raised.
  assign in_ready = (state_q == S_ACCEPT) && !start;
  assign memWrite = (state_q == S_WRITE) && !start;
  assign memAddr  = ptr_q;
  assign memData  = word_q;
  assign busy     = (state_q == S_ACCEPT) || (state_q == S_WRITE);
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERROR);
  assign count    = count_q;
  assign state_o  = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= BASE;
      count_q <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
    end else if (start) begin
      state_q <= S_ACCEPT;
      ptr_q   <= BASE;
      count_q <= '0;
    end else begin
      case (state_q)
        S_ACCEPT: begin
          // in_ready equals (state is ACCEPT) here because start is low.
          if (in_valid) begin
            if (op_legal) begin
              word_q  <= enc_word;
              last_q  <= in_last;
              state_q <= S_WRITE;
            end else begin
              state_q <= S_ERROR;
            end
          end
        end
        S_WRITE: begin
          count_q <= count_q + (ADDR_W + 1)'(1);
          // The pointer saturates at the top of memory instead of wrapping.
          if (ptr_q != PTR_MAX) begin
            ptr_q <= ptr_q + ADDR_W'(1);
          end
          if (last_q) begin
            state_q <= S_DONE;
          end else if (ptr_q == PTR_MAX) begin
            state_q <= S_ERROR;
          end else begin
            state_q <= S_ACCEPT;
          end
        end
        default: begin
          // IDLE, DONE and ERROR only leave on start.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder. Two instances share the request inputs: dut_a
// (ADDR_W=8) for the main scenarios and dut_b (ADDR_W=2) for pointer
// overflow. sel picks which instance the driver and scoreboard follow.
module tb_instr_encoder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        in_last;

  logic        a_ready, a_memWrite, a_busy, a_done, a_err;
  logic [7:0]  a_memAddr;
  logic [31:0] a_memData;
  logic [8:0]  a_count;
  logic [2:0]  a_state;

  logic        b_ready, b_memWrite, b_busy, b_done, b_err;
  logic [1:0]  b_memAddr;
  logic [31:0] b_memData;
  logic [2:0]  b_count;
  logic [2:0]  b_state;

  bit          sel;
  int          errors;
  int          checks;
  logic [39:0] exp_q[$];

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(a_ready), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
    .in_last(in_last), .memWrite(a_memWrite), .memAddr(a_memAddr),
    .memData(a_memData), .busy(a_busy), .done(a_done), .err(a_err),
    .count(a_count), .state_o(a_state)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(b_ready), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
    .in_last(in_last), .memWrite(b_memWrite), .memAddr(b_memAddr),
    .memData(b_memData), .busy(b_busy), .done(b_done), .err(b_err),
    .count(b_count), .state_o(b_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_encode(input int op, input int rs,
      input int rt, input int rd, input int imm, input int tgt);
    longint w;
    int     f;
    int     opc;
    w = 0;
    f = 0;
    opc = 0;
    if (op >= 1 && op <= 5) begin
      case (op)
        1: f = 32;
        2: f = 34;
        3: f = 36;
        4: f = 37;
        default: f = 42;
      endcase
      w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 + f;
    end else if (op == 10) begin
      w = longint'(2) * 67108864 + tgt;
    end else if (op != 0) begin
      case (op)
        6: opc = 35;
        7: opc = 43;
        8: opc = 8;
        9: opc = 12;
        11: opc = 4;
        default: opc = 5;
      endcase
      w = longint'(opc) * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + imm;
    end
    return w[31:0];
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic        mw;
    logic [39:0] got;
    logic [39:0] exp;
    mw  = sel ? b_memWrite : a_memWrite;
    got = sel ? {6'd0, b_memAddr, b_memData} : {a_memAddr, a_memData};
    if (mw === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h", got[39:32], got[31:0]);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL write got addr=%h data=%h expected addr=%h data=%h",
                   got[39:32], got[31:0], exp[39:32], exp[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the
  // handshake, i.e. inside the WRITE cycle for a legal op.
  task automatic send_req(input int op, input int rs, input int rt,
      input int rd, input int imm, input int tgt, input bit lst,
      input int gap, input bit may_stall, output bit acc);
    in_valid = 1'b0;
    idle(gap);
    in_op = 4'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_imm = 16'(imm); in_target = 26'(tgt); in_last = lst;
    in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      if ((sel ? b_ready : a_ready) === 1'b1) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    // Scramble the fields so any late sampling shows up as a wrong word.
    in_op = 4'($urandom_range(0, 15)); in_rs = 5'($urandom); in_rt = 5'($urandom);
    in_rd = 5'($urandom); in_imm = 16'($urandom); in_target = 26'($urandom);
    in_last = 1'($urandom);
    if (!acc && !may_stall) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout op=%0d got no in_ready required in_ready=1", op);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({a_ready, a_memWrite, a_busy, a_done, a_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b required=00000",
               {a_ready, a_memWrite, a_busy, a_done, a_err});
    end
    checks++;
    if (a_memAddr !== 8'd0 || a_memData !== 32'd0 || a_count !== 9'd0) begin
      errors++;
      $display("FAIL reset_regs got addr=%h data=%h count=%0d required 0/0/0",
               a_memAddr, a_memData, a_count);
    end
    checks++;
    if (a_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state got=%0d required=0", a_state);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_plan_sequence();
    bit acc;
    sel = 1'b0;
    pulse_start();
    exp_q.push_back({8'd0, 32'h00221820});
    exp_q.push_back({8'd1, 32'h8FA80004});
    exp_q.push_back({8'd2, 32'h08000010});
    send_req(1, 1, 2, 3, 16'h1234, 0, 1'b0, 0, 1'b0, acc);
    send_req(6, 29, 8, 7, 4, 0, 1'b0, 0, 1'b0, acc);
    send_req(10, 5, 6, 7, 0, 26'h10, 1'b1, 0, 1'b0, acc);
    idle(1);
    @(negedge clk);
    checks++;
    if (a_done !== 1'b1 || a_count !== 9'd3 || a_busy !== 1'b0 || a_err !== 1'b0) begin
      errors++;
      $display("FAIL plan_status got done=%b count=%0d busy=%b err=%b required 1/3/0/0",
               a_done, a_count, a_busy, a_err);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL plan_pending got %0d unwritten required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_branch_gaps();
    bit acc;
    sel = 1'b0;
    pulse_start();
    exp_q.push_back({8'd0, 32'h1022FFFF});
    exp_q.push_back({8'd1, 32'h1422FFFF});
    send_req(11, 1, 2, 9, 16'hFFFF, 0, 1'b0, 3, 1'b0, acc);
    send_req(12, 1, 2, 9, 16'hFFFF, 0, 1'b1, 2, 1'b0, acc);
    idle(6);
    @(negedge clk);
    checks++;
    if (a_done !== 1'b1 || a_count !== 9'd2) begin
      errors++;
      $display("FAIL branch_status got done=%b count=%0d required 1/2", a_done, a_count);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL branch_pending got %0d unwritten required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_illegal_op();
    bit acc;
    sel = 1'b0;
    pulse_start();
    exp_q.push_back({8'd0, model_encode(2, 4, 5, 6, 0, 0)});
    send_req(2, 4, 5, 6, 0, 0, 1'b0, 0, 1'b0, acc);
    send_req(14, 4, 5, 6, 0, 0, 1'b1, 0, 1'b0, acc);
    @(negedge clk);
    checks++;
    if (a_err !== 1'b1 || a_busy !== 1'b0 || a_count !== 9'd1 || a_ready !== 1'b0) begin
      errors++;
      $display("FAIL illegal_status got err=%b busy=%b count=%0d ready=%b required 1/0/1/0",
               a_err, a_busy, a_count, a_ready);
    end
    @(posedge clk);
    #1;
    idle(4);
    pulse_start();
    @(negedge clk);
    checks++;
    if (a_err !== 1'b0 || a_busy !== 1'b1 || a_ready !== 1'b1 || a_count !== 9'd0
        || a_memAddr !== 8'd0) begin
      errors++;
      $display("FAIL illegal_restart got err=%b busy=%b ready=%b count=%0d addr=%h required 0/1/1/0/00",
               a_err, a_busy, a_ready, a_count, a_memAddr);
    end
    @(posedge clk);
    #1;
    exp_q.push_back({8'd0, model_encode(9, 3, 3, 0, 16'h00FF, 0)});
    send_req(9, 3, 3, 0, 16'h00FF, 0, 1'b1, 1, 1'b0, acc);
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL illegal_pending got %0d unwritten required 0", exp_q.size());
    end
  endtask

  task automatic test_overflow();
    bit acc;
    sel = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({8'(i), model_encode(8, i, i + 1, 0, 100 + i, 0)});
      send_req(8, i, i + 1, 0, 100 + i, 0, 1'b0, i % 2, 1'b0, acc);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (b_err !== 1'b1 || b_count !== 3'd4 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL overflow_status got err=%b count=%0d busy=%b required 1/4/0",
               b_err, b_count, b_busy);
    end
    @(posedge clk);
    #1;
    send_req(1, 1, 1, 1, 0, 0, 1'b0, 0, 1'b1, acc);
    checks++;
    if (acc !== 1'b0 || b_ready !== 1'b0) begin
      errors++;
      $display("FAIL overflow_accept got accepted=%b ready=%b required 0/0", acc, b_ready);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL overflow_pending got %0d unwritten required 0", exp_q.size());
    end
    sel = 1'b0;
  endtask

  task automatic test_start_in_write();
    bit acc;
    sel = 1'b0;
    pulse_start();
    send_req(3, 7, 8, 9, 0, 0, 1'b0, 0, 1'b0, acc);
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (a_memWrite !== 1'b0) begin
      errors++;
      $display("FAIL start_suppress got memWrite=%b required 0", a_memWrite);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (a_count !== 9'd0 || a_busy !== 1'b1 || a_ready !== 1'b1 || a_memAddr !== 8'd0) begin
      errors++;
      $display("FAIL start_restart got count=%0d busy=%b ready=%b addr=%h required 0/1/1/00",
               a_count, a_busy, a_ready, a_memAddr);
    end
    @(posedge clk);
    #1;
    exp_q.push_back({8'd0, model_encode(4, 10, 11, 12, 0, 0)});
    send_req(4, 10, 11, 12, 0, 0, 1'b1, 0, 1'b0, acc);
    idle(1);
    @(negedge clk);
    checks++;
    if (a_done !== 1'b1 || a_count !== 9'd1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL start_session got done=%b count=%0d pending=%0d required 1/1/0",
               a_done, a_count, exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_in_write();
    bit acc;
    sel = 1'b0;
    pulse_start();
    send_req(5, 1, 2, 3, 0, 0, 1'b0, 0, 1'b0, acc);
    #1;
    checks++;
    if (a_memWrite !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_write got memWrite=%b required 1", a_memWrite);
    end
    // This write is cut short by reset, so the scoreboard must never see it.
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_memWrite, a_ready, a_busy, a_done, a_err} !== 5'b0 || a_count !== 9'd0
        || a_memAddr !== 8'd0 || a_memData !== 32'd0 || a_state !== 3'd0) begin
      errors++;
      $display("FAIL rst_async got flags=%b count=%0d addr=%h data=%h state=%0d required all 0",
               {a_memWrite, a_ready, a_busy, a_done, a_err}, a_count, a_memAddr,
               a_memData, a_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    bit acc;
    int n;
    int op, rs, rt, rd, imm, tgt;
    sel = 1'b0;
    for (int s = 0; s < 3; s++) begin
      pulse_start();
      n = $urandom_range(5, 12);
      for (int i = 0; i < n; i++) begin
        op  = $urandom_range(0, 12);
        rs  = $urandom_range(0, 31);
        rt  = $urandom_range(0, 31);
        rd  = $urandom_range(0, 31);
        imm = $urandom_range(0, 65535);
        tgt = $urandom_range(0, 67108863);
        exp_q.push_back({8'(i), model_encode(op, rs, rt, rd, imm, tgt)});
        send_req(op, rs, rt, rd, imm, tgt, (i == n - 1), $urandom_range(0, 3), 1'b0, acc);
      end
      idle(1);
      @(negedge clk);
      checks++;
      if (a_done !== 1'b1 || a_count !== 9'(n) || exp_q.size() != 0) begin
        errors++;
        $display("FAIL random_session%0d got done=%b count=%0d pending=%0d required 1/%0d/0",
                 s, a_done, a_count, exp_q.size(), n);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    errors = 0;
    checks = 0;
    sel = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_imm = '0; in_target = '0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    idle(1);
    test_plan_sequence();
    test_branch_gaps();
    test_illegal_op();
    test_overflow();
    test_start_in_write();
    test_reset_in_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
